// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch unit.
package fetch_pkg;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} fetch_state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory request/response channel.
interface inst_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    modport master(output req_valid, req_addr, input req_ready, resp_valid, resp_data);
    modport slave(input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: fetched-instruction buffer with synchronous clear; head is fully registered.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int           DEPTH     = 2,
    parameter fetch_entry_t RST_ENTRY = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_ENTRY;
        end else if (clear) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) mem[wr] <= din;
            wr  <= do_push ? wr + 1'b1 : wr;
            rd  <= do_pop ? rd + 1'b1 : rd;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetcher feeding decode through fetch_fifo.
// Define FETCH_ALIGN_CHECK_EN to flag misaligned redirect targets and halt fetching.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_if.master        imem,
    input  logic                stall_d,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    output logic [31:0]         inst,
    output logic [31:0]         pc,
    output logic                valid_d,
    output logic                addr_err
);
    localparam fetch_entry_t RST_ENTRY = '{pc: RESET_PC, inst: 32'h0};
    fetch_state_t state;
    fetch_entry_t head, rsp_entry;
    logic [31:0] fetch_pc, req_pc, target;
    logic full, empty, accept, push, pop;
`ifdef FETCH_ALIGN_CHECK_EN
    assign target = branch_target;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_err <= 1'b0;
        else if (branch_taken && |branch_target[1:0]) addr_err <= 1'b1;
    end
`else
    assign target   = branch_target & ~32'h3;
    assign addr_err = 1'b0;
`endif
    assign imem.req_valid = state == S_REQ && !full && !addr_err;
    assign imem.req_addr  = fetch_pc;
    assign accept    = imem.req_valid && imem.req_ready;
    // a redirect kills the response of the cycle it arrives in
    assign push      = state == S_WAIT && imem.resp_valid && !branch_taken;
    assign pop       = valid_d && !stall_d && !branch_taken;
    assign rsp_entry = '{pc: req_pc, inst: imem.resp_data};
    assign valid_d   = !empty;
    assign inst      = head.inst;
    assign pc        = head.pc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            fetch_pc <= branch_taken ? target : accept ? fetch_pc + 32'd4 : fetch_pc;
            req_pc   <= accept ? fetch_pc : req_pc;
            case (state)
                S_REQ:   state <= accept ? (branch_taken ? S_DROP : S_WAIT) : S_REQ;
                S_WAIT:  state <= imem.resp_valid ? S_REQ : branch_taken ? S_DROP : S_WAIT;
                S_DROP:  state <= imem.resp_valid ? S_REQ : S_DROP;
                default: state <= S_REQ;
            endcase
        end
    end
    fetch_fifo #(.DEPTH(BUF_DEPTH), .RST_ENTRY(RST_ENTRY)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .clear(branch_taken),
        .din  (rsp_entry),
        .full (full),
        .empty(empty),
        .head (head)
    );
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, is the first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, is the fetch-buffer depth in entries; legal values are 2 and 4.
REQ-003 Port clk, input, 1 bit, is the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit, is the asynchronous active-high reset.
REQ-005 Port imem_req_valid, output, 1 bit, signals an instruction-memory read request.
REQ-006 Port imem_req_addr, output, 32 bits, carries the word-aligned request address.
REQ-007 Port imem_req_ready, input, 1 bit, means memory accepts the request this cycle.
REQ-008 Port imem_resp_valid, input, 1 bit, signals that read data is valid.
REQ-009 Port imem_resp_data, input, 32 bits, carries the instruction word.
REQ-010 Port stall_d, input, 1 bit, means decode holds its current instruction.
REQ-011 Port branch_taken, input, 1 bit, requests a redirect.
REQ-012 Port branch_target, input, 32 bits, carries the redirect address.
REQ-013 Port inst, output, 32 bits, is the instruction presented to decode.
REQ-014 Port pc, output, 32 bits, is the address of inst.
REQ-015 Port valid_d, output, 1 bit, means inst and pc are valid.
REQ-016 Port addr_err, output, 1 bit, is the sticky misaligned-target flag.

Function
REQ-017 At most one memory request shall be outstanding; a request completes on imem_resp_valid, at least 1 cycle after acceptance.
REQ-018 FSM states shall be REQ, WAIT and DROP, with the following transitions:
- REQ->WAIT on imem_req_valid and imem_req_ready.
- WAIT->REQ on a response.
- WAIT->DROP on branch_taken without a response.
- DROP->REQ on a response.
REQ-019 imem_req_valid shall be high only in REQ, and only when FIFO occupancy is below BUF_DEPTH.
REQ-020 imem_req_addr shall equal fetch_pc; it shall stay stable while imem_req_valid is high and imem_req_ready is low.
REQ-021 On request acceptance, fetch_pc shall advance by 4 with 32-bit wrap (32'hFFFF_FFFC -> 32'h0).
REQ-022 A response in WAIT without branch_taken shall push {req_pc, imem_resp_data} into the FIFO.
REQ-023 A response in DROP shall be discarded.
REQ-024 valid_d shall equal FIFO non-empty, and inst/pc shall be the FIFO head with no combinational path from imem_resp_data.
REQ-025 The head shall pop when valid_d is high and stall_d is low.
REQ-026 A push and a pop in the same cycle shall leave occupancy unchanged.
REQ-027 branch_taken has priority over every other event; in the same cycle it shall:
- clear the FIFO;
- load fetch_pc with branch_target;
- cancel any pop;
- force valid_d low in the next cycle.
REQ-028 branch_taken in REQ, with a request accepted that same cycle, shall enter DROP.
REQ-029 branch_taken in WAIT coincident with a response shall discard that response and enter REQ.
REQ-030 First valid_d after reset or redirect shall rise 2 cycles after acceptance if memory responds 1 cycle after acceptance.

Reset
REQ-031 rst high shall immediately force:
- state to REQ;
- fetch_pc to RESET_PC;
- the FIFO empty;
- valid_d, inst and addr_err to 0;
- pc to RESET_PC.
REQ-032 Reset asserted mid-transaction shall drop the outstanding request state, and any response arriving after deassertion while in REQ shall be ignored.

Configuration
REQ-033 With FETCH_ALIGN_CHECK_EN defined, a redirect where branch_target[1:0] != 0 shall:
- set addr_err;
- block all further requests until reset.
REQ-034 Without FETCH_ALIGN_CHECK_EN:
- branch_target[1:0] shall be forced to 0;
- addr_err shall be tied 0.

Structure
REQ-035 A shared package fetch_pkg shall hold:
- the FSM state enum;
- the fetch-entry struct {pc[31:0], inst[31:0]};
- the RESET_PC default.
REQ-036 The FIFO shall be a sub-module, fetch_fifo, parameterised by BUF_DEPTH, with push, pop, clear, full, empty and head ports.

Verification
REQ-037 Reset, zero-wait memory, stall_d=0 -> decode sees pc 0xBFC00000, 0xBFC00004, 0xBFC00008 with one instruction every 2 cycles.
REQ-038 stall_d high for 5 cycles -> occupancy reaches BUF_DEPTH, imem_req_valid drops, and inst/pc hold.
REQ-039 Release stall_d -> no instruction is lost or duplicated.
REQ-040 branch_taken=1 with target 0x80001000 while in WAIT:
- the stale response is dropped;
- the next pc is 0x80001000;
- valid_d is low the following cycle.
REQ-041 branch_taken coincident with a response, target 0x80002000 -> the response is discarded and the next request address is 0x80002000.
REQ-042 Target 0x80001002 with FETCH_ALIGN_CHECK_EN -> addr_err=1 and no further requests; without the macro -> fetch from 0x80001000.
REQ-043 rst pulse while in WAIT -> outputs return to reset values within the same cycle, and refetch starts at 0xBFC00000.
